// File: rtl/addr_gen_unit.sv
// Address generator: base + (optionally scaled) sign-extended IR offset,
// results queued in a small in-order FIFO with carry/overflow flags.
module addr_gen_unit #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1,
  parameter int DEPTH = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             addr1_sel,
  input  logic [1:0]             addr2_sel,
  input  logic                   scale_en,
  input  logic [15:0]            IR,
  input  logic [WIDTH-1:0]       PC,
  input  logic [WIDTH-1:0]       SR1_OUT,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       offset,
  output logic                   carry,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_off_raw;
  logic [WIDTH-1:0] w_off;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_out;
  logic             w_push;
  logic             w_pop;
  logic             w_ir_unused;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_last;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign w_ir_unused = ^IR[15:11];

  always_comb begin
    w_base = '0;
    case (addr1_sel)
      2'b00:   w_base = PC;
      2'b01:   w_base = SR1_OUT;
      default: w_base = '0;
    endcase
  end

  always_comb begin
    w_off_raw = '0;
    case (addr2_sel)
      2'b01:   w_off_raw = {{(WIDTH-6){IR[5]}}, IR[5:0]};
      2'b10:   w_off_raw = {{(WIDTH-9){IR[8]}}, IR[8:0]};
      2'b11:   w_off_raw = {{(WIDTH-11){IR[10]}}, IR[10:0]};
      default: w_off_raw = '0;
    endcase
  end

  assign w_off   = scale_en ? (w_off_raw << SHIFT) : w_off_raw;
  assign w_sum   = {1'b0, w_base} + {1'b0, w_off};
  // Overflow: operands agree in sign but the truncated result does not.
  assign w_ovf   = (w_base[WIDTH-1] == w_off[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_base[WIDTH-1]);
  assign w_entry = {w_sum[WIDTH], w_ovf, w_sum[WIDTH-1:0]};

  // Handshake: a transfer happens on a rising Clk edge only when valid and
  // ready are both high; in_ready depends on registered occupancy alone.
  assign in_ready  = !Reset && (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  assign w_head = r_mem[r_rd_ptr];
  assign w_out  = out_valid ? w_head : r_last;
  assign {carry, ovf, offset} = w_out;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_last   <= w_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/addr_gen_unit.md
ADDR_GEN_UNIT -- requirements
Module: addr_gen_unit

Interface
REQ-001 Parameter WIDTH, default 16: address/operand width; SHALL be >= 16.
REQ-002 Parameter SHIFT, default 1: left-shift applied to the selected offset when scale_en=1; legal range 0..3.
REQ-003 Parameter DEPTH, default 2: output buffer entries; legal values 2 or 4.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 addr1_sel  input  2  base select: 00 PC, 01 SR1_OUT, 10 zero, 11 zero.
REQ-009 addr2_sel  input  2  offset select: 00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0]).
REQ-010 scale_en  input  1  apply SHIFT to selected offset.
REQ-011 IR  input  16  instruction word.
REQ-012 PC  input  WIDTH  program counter.
REQ-013 SR1_OUT  input  WIDTH  register-file source 1.
REQ-014 out_valid  output  1  buffer head holds a result.
REQ-015 out_ready  input  1  consumer takes head this cycle.
REQ-016 offset  output  WIDTH  computed address at buffer head.
REQ-017 carry  output  1  unsigned carry-out of head result.
REQ-018 ovf  output  1  signed overflow of head result.
REQ-019 count  output  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-020 Request accepted on a rising Clk edge when in_valid=1 and in_ready=1; no other edge accepts.
REQ-021 All operand inputs SHALL be sampled only at the accepting edge; later changes do not affect stored results.
REQ-022 Offset term: IR field sign-extended to WIDTH, then shifted left SHIFT bits (zero fill, truncated to WIDTH) if scale_en=1.
REQ-023 Result = base + offset term, modulo 2^WIDTH; carry = bit WIDTH of the unsigned sum; ovf = 1 when both operands share a sign bit differing from the result's sign bit.
REQ-024 Result, carry, ovf SHALL be computed combinationally at accept and written into a DEPTH-entry FIFO; latency accept-to-out_valid = 1 cycle.
REQ-025 Head popped at a rising edge when out_valid=1 and out_ready=1.
REQ-026 in_ready = (count < DEPTH), combinational from registered count only (no path from out_ready).
REQ-027 out_valid = (count != 0); offset/carry/ovf reflect head entry; when count=0 they SHALL hold the last popped values (0 after reset).
REQ-028 Simultaneous push and pop: count unchanged, FIFO order preserved.
REQ-029 Full (count=DEPTH): in_ready=0, in_valid ignored; after a pop, in_ready rises next cycle.
REQ-030 Empty: out_ready ignored, no pointer movement.
REQ-031 Read/write pointers wrap modulo DEPTH without loss or duplication.
REQ-032 Results SHALL leave in acceptance order; no reordering or dropping.

Reset
REQ-033 Reset asserted: count=0, pointers=0, out_valid=0, in_ready=0 while Reset=1, offset=0, carry=0, ovf=0, immediately (asynchronous).
REQ-034 Reset mid-operation discards all buffered entries; no result from before reset SHALL appear afterwards.
REQ-035 in_ready=1 on the first cycle after Reset deasserts.

Verification
REQ-036 PC=16'h3000, addr1_sel=00, addr2_sel=10, IR[8:0]=9'h1FF, scale_en=0, out_ready=1 -> next cycle out_valid=1, offset=16'h2FFF, carry=1, ovf=0.
REQ-037 SR1_OUT=16'h7FFF, addr1_sel=01, addr2_sel=01, IR[5:0]=6'h01 -> offset=16'h8000, ovf=1, carry=0.
REQ-038 addr1_sel=10, addr2_sel=11, IR[10:0]=11'h002, scale_en=1, SHIFT=1 -> offset=16'h0004.
REQ-039 out_ready=0, three back-to-back requests A,B,C with DEPTH=2 -> in_ready=0 after two accepts, C held; raise out_ready -> A, B, C emerge in order, count returns 0.
REQ-040 count=DEPTH-1 with in_valid=1 and out_ready=1 same cycle -> count unchanged, order preserved across pointer wrap.
REQ-041 Two entries buffered, assert Reset mid-cycle -> out_valid=0 and count=0 immediately; after release no stale entry appears.
